// File: rtl/mult_arbiter.sv
// mult_arbiter
//   Round-robin front end that shares one 32x32 (approximate) multiplier
//   among NREQ requesters. A granted request is registered into the
//   multiplier operand stage (stage 1). The combinational product is then
//   captured into a shared result register with a one-hot owner strobe
//   (stage 2). Per-mode saturating counters track issued operations.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   clk_en            all state advances only when high
//   req_valid/ready   per-requester handshake; ready is one-hot or zero
//   req_a, req_b      packed operands, requester i at [32i+31:32i]
//   req_precise       per-request precise-mode flag
//   force_precise     forces precise mode for requests issued while high
//   mul_a, mul_b      registered operands to the shared multiplier
//   mul_precise_en    registered mode to the shared multiplier
//   mul_y             combinational product from the shared multiplier
//   rsp_valid         one-hot result strobe (gated by clk_en)
//   rsp_y             registered result, shared by all requesters
//   busy              an operation is in stage 1 or stage 2
//   cnt_precise/approx  saturating issued-operation counters per mode
module mult_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ-1:0]      req_precise,
  input  logic                 force_precise,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  output logic                 mul_precise_en,
  input  logic [63:0]          mul_y,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [63:0]          rsp_y,
  output logic                 busy,
  output logic [31:0]          cnt_precise,
  output logic [31:0]          cnt_approx
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   id1;
  logic            v1;
  logic [NREQ-1:0] rsp_q;

  logic [IW-1:0]   grant_id;
  logic            grant_any;
  logic            xfer;
  logic            issue_precise;
  logic [31:0]     a_arr [NREQ];
  logic [31:0]     b_arr [NREQ];

  // Unpack the flat operand buses so the granted operands can be muxed by index.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[32*gi +: 32];
      assign b_arr[gi] = req_b[32*gi +: 32];
    end
  endgenerate

  // (p + k) mod NREQ, valid for any NREQ, not only powers of two.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Search starts at rr_ptr and walks upward with wrap; first valid wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any && req_valid[wrap_add(rr_ptr, k)]) begin
        grant_any = 1'b1;
        grant_id  = wrap_add(rr_ptr, k);
      end
    end
  end

  // rst is included so no grant is ever shown while reset is held.
  always_comb begin
    req_ready = '0;
    if (grant_any && clk_en && !rst) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign xfer          = |req_ready;
  assign issue_precise = req_precise[grant_id] | force_precise;

  // Round-robin pointer: moves past the winner, holds when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (clk_en && xfer) begin
      rr_ptr <= wrap_add(grant_id, 1);
    end
  end

  // Stage 1: operand/mode registers feeding the shared multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1             <= 1'b0;
      id1            <= '0;
      mul_a          <= '0;
      mul_b          <= '0;
      mul_precise_en <= 1'b0;
    end else if (clk_en) begin
      v1 <= xfer;
      if (xfer) begin
        id1            <= grant_id;
        mul_a          <= a_arr[grant_id];
        mul_b          <= b_arr[grant_id];
        mul_precise_en <= issue_precise;
      end
    end
  end

  // Stage 2: capture the product and mark its owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_y <= '0;
      rsp_q <= '0;
    end else if (clk_en) begin
      rsp_y <= mul_y;
      rsp_q <= v1 ? (NREQ'(1) << id1) : '0;
    end
  end

  // Issued-operation counters; they stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_precise <= '0;
      cnt_approx  <= '0;
    end else if (clk_en && xfer) begin
      if (issue_precise) begin
        if (cnt_precise != 32'hFFFF_FFFF) cnt_precise <= cnt_precise + 32'd1;
      end else begin
        if (cnt_approx != 32'hFFFF_FFFF) cnt_approx <= cnt_approx + 32'd1;
      end
    end
  end

  // A response held across a clk_en=0 stretch is only presented once enabled.
  assign rsp_valid = rsp_q & {NREQ{clk_en}};
  assign busy      = v1 | (rsp_q != '0);

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              clk_en;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]   req_precise;
  logic              force_precise;
  logic [31:0]       mul_a;
  logic [31:0]       mul_b;
  logic              mul_precise_en;
  logic [63:0]       mul_y;
  logic [NREQ-1:0]   rsp_valid;
  logic [63:0]       rsp_y;
  logic              busy;
  logic [31:0]       cnt_precise;
  logic [31:0]       cnt_approx;

  int checks = 0;
  int errors = 0;

  mult_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_precise(req_precise),
    .force_precise(force_precise),
    .mul_a(mul_a), .mul_b(mul_b), .mul_precise_en(mul_precise_en),
    .mul_y(mul_y),
    .rsp_valid(rsp_valid), .rsp_y(rsp_y), .busy(busy),
    .cnt_precise(cnt_precise), .cnt_approx(cnt_approx)
  );

  // Exact product stands in for the shared multiplier.
  assign mul_y = {32'b0, mul_a} * {32'b0, mul_b};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  logic [63:0] fair_prod [4];

  initial begin
    rst = 1'b1; clk_en = 1'b1; req_valid = 4'b1111;
    req_a = '0; req_b = '0; req_precise = '0; force_precise = 1'b0;
    fair_prod[0] = 64'h0001_0000; fair_prod[1] = 64'h0002_2000;
    fair_prod[2] = 64'h0003_6000; fair_prod[3] = 64'h0004_C000;

    // Reset state
    @(negedge clk); #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_y", rsp_y, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_precise_en", mul_precise_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt_p", cnt_precise, 0);
    chk("rst_cnt_a", cnt_approx, 0);

    // First grant after reset: lowest valid index
    rst = 1'b0; req_valid = 4'b1010; #1;
    chk("first_grant", req_ready, 4'b0010);

    // Single precise op on requester 2
    req_valid = 4'b0100; req_precise = 4'b0100;
    set_op(2, 32'h0001_0003, 32'h0002_0005); #1;
    chk("single_ready", req_ready, 4'b0100);
    step; req_valid = '0; #1;
    chk("single_mul_a", mul_a, 32'h0001_0003);
    chk("single_mul_b", mul_b, 32'h0002_0005);
    chk("single_mode", mul_precise_en, 1);
    chk("single_busy", busy, 1);
    chk("single_rsp_early", rsp_valid, 0);
    step; #1;
    chk("single_rsp_valid", rsp_valid, 4'b0100);
    chk("single_rsp_y", rsp_y, 64'h0000_0002_000B_000F);
    chk("single_cnt_p", cnt_precise, 1);
    chk("single_cnt_a", cnt_approx, 0);
    step; #1;
    chk("single_idle_busy", busy, 0);
    chk("single_idle_rsp", rsp_valid, 0);

    // Fairness: all four valid for 8 cycles
    pulse_reset;
    for (int i = 0; i < 4; i++) set_op(i, 32'h10 + i, 32'h1000 * (i + 1));
    req_precise = 4'b0101;
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 8) ? 4'b1111 : 4'b0000; #1;
      chk($sformatf("fair_ready_%0d", k), req_ready, (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000);
      if (k >= 2) begin
        chk($sformatf("fair_rsp_%0d", k), rsp_valid, 4'b0001 << ((k - 2) % 4));
        chk($sformatf("fair_y_%0d", k), rsp_y, fair_prod[(k - 2) % 4]);
      end else begin
        chk($sformatf("fair_rsp_%0d", k), rsp_valid, 0);
      end
      step;
    end
    #1;
    chk("fair_cnt_p", cnt_precise, 4);
    chk("fair_cnt_a", cnt_approx, 4);
    chk("fair_busy", busy, 0);

    // Mode mixing: req0 approx then req1 precise
    pulse_reset;
    req_precise = 4'b0010; force_precise = 1'b0;
    set_op(0, 32'd3, 32'd5); set_op(1, 32'd7, 32'd9);
    req_valid = 4'b0001; #1;
    chk("mix_ready0", req_ready, 4'b0001);
    step; req_valid = 4'b0010; #1;
    chk("mix_ready1", req_ready, 4'b0010);
    chk("mix_mode0", mul_precise_en, 0);
    step; req_valid = '0; #1;
    chk("mix_mode1", mul_precise_en, 1);
    chk("mix_rsp0", rsp_valid, 4'b0001);
    chk("mix_y0", rsp_y, 64'd15);
    step; #1;
    chk("mix_rsp1", rsp_valid, 4'b0010);
    chk("mix_y1", rsp_y, 64'd63);
    chk("mix_cnt_a", cnt_approx, 1);
    chk("mix_cnt_p", cnt_precise, 1);

    // force_precise overrides an approx request; dropping it later has no effect
    req_precise = '0; force_precise = 1'b1;
    set_op(2, 32'h100, 32'h100);
    req_valid = 4'b0100; #1;
    chk("force_ready", req_ready, 4'b0100);
    step; force_precise = 1'b0; req_valid = '0; #1;
    chk("force_mode", mul_precise_en, 1);
    chk("force_cnt_p", cnt_precise, 2);
    chk("force_cnt_a", cnt_approx, 1);
    step; #1;
    chk("force_rsp", rsp_valid, 4'b0100);
    chk("force_y", rsp_y, 64'h1_0000);
    step;

    // clk_en stall right after a transfer on requester 3
    set_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid = 4'b1000; #1;
    chk("stall_grant", req_ready, 4'b1000);
    step; clk_en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk($sformatf("stall_ready_%0d", s), req_ready, 0);
      chk($sformatf("stall_rsp_%0d", s), rsp_valid, 0);
      chk($sformatf("stall_busy_%0d", s), busy, 1);
      step;
    end
    clk_en = 1'b1; req_valid = '0; #1;
    chk("stall_resume_rsp", rsp_valid, 0);
    step; clk_en = 1'b0; #1;
    chk("stall_held_rsp", rsp_valid, 0);
    chk("stall_held_busy", busy, 1);
    step; clk_en = 1'b1; #1;
    chk("stall_rsp", rsp_valid, 4'b1000);
    chk("stall_y", rsp_y, 64'hFFFF_FFFE_0000_0001);
    step; #1;
    chk("stall_once", rsp_valid, 0);
    chk("stall_idle", busy, 0);

    // Reset with ops in both stages
    set_op(0, 32'd2, 32'd2); set_op(1, 32'd4, 32'd4);
    req_valid = 4'b0001; step;
    req_valid = 4'b0010; step;
    rst = 1'b1; req_valid = 4'b0011; #1;
    chk("mrst_ready", req_ready, 0);
    chk("mrst_rsp", rsp_valid, 0);
    chk("mrst_rsp_y", rsp_y, 0);
    chk("mrst_mul_a", mul_a, 0);
    chk("mrst_mul_b", mul_b, 0);
    chk("mrst_mode", mul_precise_en, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_cnt_p", cnt_precise, 0);
    chk("mrst_cnt_a", cnt_approx, 0);
    step; rst = 1'b0; req_valid = '0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk($sformatf("mrst_ghost_%0d", s), rsp_valid, 0);
      chk($sformatf("mrst_ghost_busy_%0d", s), busy, 0);
      step;
    end

    // Counter saturation
    force dut.cnt_precise = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_precise;
    req_precise = 4'b0011;
    req_valid = 4'b0001; #1;
    step; req_valid = 4'b0010; #1;
    chk("sat_first", cnt_precise, 32'hFFFF_FFFF);
    step; req_valid = '0; #1;
    chk("sat_hold", cnt_precise, 32'hFFFF_FFFF);
    chk("sat_cnt_a", cnt_approx, 0);
    step;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one 32x32 approximate multiplier; legal range 2..8.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 clk_en  input  1  state advances only when 1.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  per-requester grant, one-hot or zero.
REQ-007 req_a, req_b  input  NREQ*32 each  operands; requester i uses bits [32i+31:32i].
REQ-008 req_precise  input  NREQ  per-request precise-mode flag.
REQ-009 force_precise  input  1  forces precise mode for every request issued while high.
REQ-010 mul_a, mul_b  output  32 each  registered operands to the shared multiplier.
REQ-011 mul_precise_en  output  1  registered mode to the shared multiplier.
REQ-012 mul_y  input  64  combinational multiplier product of mul_a, mul_b.
REQ-013 rsp_valid  output  NREQ  one-hot result strobe.
REQ-014 rsp_y  output  64  registered result, shared by all requesters.
REQ-015 busy  output  1  high when any operation is in flight.
REQ-016 cnt_precise, cnt_approx  output  32 each  issued-operation counters, per mode.

Function
REQ-017 Handshake: a transfer occurs on a clock edge with clk_en=1 and req_valid[i]&req_ready[i]=1.
REQ-018 At most one req_ready bit is high per cycle.
REQ-019 req_ready is combinational from req_valid, rr_ptr and clk_en; it is all-zero when clk_en=0 or rst=1.
REQ-020 Round-robin: the grant goes to the first valid requester at or after rr_ptr, in ascending index order with wrap from NREQ-1 to 0.
REQ-021 After a grant to i, rr_ptr becomes (i+1) mod NREQ; with no grant, rr_ptr holds.
REQ-022 Stage 1, at the transfer edge: mul_a, mul_b and id1 load from the granted requester.
REQ-023 Stage 1 also loads mul_precise_en = req_precise[i] | force_precise, and sets v1=1; with no transfer, v1 is 0 and mul_a, mul_b, mul_precise_en hold.
REQ-024 Stage 2, at the next enabled edge: rsp_y loads mul_y, and rsp_q becomes one-hot(id1) if v1, else 0.
REQ-025 Latency: a transfer at enabled edge N gives rsp_valid[i] in the cycle following enabled edge N+1.
REQ-026 Throughput is one operation per enabled cycle; there is no response backpressure, so requesters must accept rsp_valid.
REQ-027 rsp_valid = rsp_q & {NREQ{clk_en}}; when clk_en=0, all registers hold and a pending response is presented on the next clk_en=1 cycle, exactly once.
REQ-028 busy = v1 | (rsp_q != 0).
REQ-029 Each transfer increments cnt_precise if the issued mode is 1, else cnt_approx.
REQ-030 Both counters saturate at 0xFFFFFFFF and do not wrap.
REQ-031 A request whose req_valid drops before it is granted is dropped, with no side effects.
REQ-032 req_a, req_b and req_precise are sampled only at the transfer edge.
REQ-033 force_precise toggling affects only requests transferred while it is high; operations already in flight keep their registered mode.

Reset
REQ-034 While rst=1, outputs are: req_ready=0, rsp_valid=0, rsp_y=0, mul_a=0, mul_b=0, mul_precise_en=0, busy=0, cnt_precise=0, cnt_approx=0.
REQ-035 While rst=1, internal state is: rr_ptr=0, v1=0, id1=0.
REQ-036 Reset asserted mid-operation discards all in-flight operations; no rsp_valid is produced for them after deassertion.
REQ-037 The first grant after reset goes to the lowest-index valid requester.

Verification
REQ-038 Single op: req 2 with a=0x0001_0003, b=0x0002_0005, precise=1 -> ready[2] at cycle 0; mul_precise_en=1 at cycle 1; rsp_valid=0b0100 with rsp_y=0x0000_0002_000B_000F at cycle 2; cnt_precise=1.
REQ-039 Fairness: all 4 requesters valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3, with one rsp_valid per cycle from cycle 2.
REQ-040 Mode mixing: req0 approx back-to-back with req1 precise, force_precise=0 -> mul_precise_en 0 then 1; cnt_approx=1, cnt_precise=1.
REQ-041 force_precise: with force_precise=1 and req_precise=0 -> mul_precise_en=1 and cnt_precise increments.
REQ-042 clk_en stall: clk_en=0 for 3 cycles right after a transfer -> rsp_valid stays 0 during the stall, then asserts for exactly one enabled cycle with the correct rsp_y.
REQ-043 Reset with v1=1 and rsp_q nonzero -> all outputs 0 immediately; no response appears after rst deasserts; counter saturation checked by forcing the counter to 0xFFFFFFFE and issuing 2 ops -> 0xFFFFFFFF.
